// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial ripple adder. A start request latches the two
//               operands, which are then added one bit per clock, LSB first.
//               After WIDTH addition cycles the sum and carry-out are copied
//               to the output registers and done pulses for one cycle.
//               A start seen during that done cycle launches the next
//               operation immediately, with no idle cycle in between.
//
// Parameters  : WIDTH  operand/sum width in bits (2..32)
//
// Ports       : clk    clock, rising-edge active
//               rst    asynchronous active-high reset
//               start  begin an addition (ignored while busy or in reset)
//               a, b   operands (WIDTH bits)
//               busy   high while the serial addition runs
//               done   one-cycle pulse: S/C (and OVF) are valid
//               S      registered sum, modulo 2^WIDTH
//               C      registered carry-out of the MSB
//               OVF    registered signed overflow (only when
//                      SERIAL_ADDER_OVF_EN is defined)
//
// Build macro : SERIAL_ADDER_OVF_EN  adds the OVF output and its logic
//
// Revision    : 1.0  initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);

    // One extra counter bit so the count reaches WIDTH without wrapping.
    localparam int c_cnt_w = $clog2(WIDTH) + 1;
    // The partial sum only needs WIDTH-1 bits: the final bit goes straight
    // from the adder into S on the last cycle.
    localparam int c_sum_w = WIDTH - 1;

    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_add  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [c_sum_w-1:0] r_sum;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;

    logic w_sum_bit;
    logic w_cout;
    logic w_last;

    // Full adder on the current LSBs.
    assign w_sum_bit = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cout    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_last    = (r_cnt == c_last_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            S       <= '0;
            C       <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            OVF     <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_st_add: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_cout;
                    // New sum bit enters at the top; older bits move down.
                    r_sum   <= c_sum_w'({w_sum_bit, r_sum} >> 1);
                    r_cnt   <= r_cnt + c_cnt_one;
                    if (w_last) begin
                        r_state <= c_st_done;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        S       <= {w_sum_bit, r_sum};
                        C       <= w_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // r_carry is the carry into the MSB on this cycle.
                        OVF     <= r_carry ^ w_cout;
`endif
                    end
                end

                // Idle and done both accept a new request; an unused
                // encoding behaves as idle.
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state <= c_st_add;
                        busy    <= 1'b1;
                        r_a     <= a;
                        r_b     <= b;
                        r_sum   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= c_st_idle;
                        busy    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder (WIDTH=8). Expected
//               results are queued when a request is driven and compared
//               when done pulses; protocol timing is checked per operation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             r_clk   = 1'b0;
    logic             r_rst   = 1'b0;
    logic             r_start = 1'b0;
    logic [WIDTH-1:0] r_a     = '0;
    logic [WIDTH-1:0] r_b     = '0;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_s;
    logic             w_c;
`ifdef SERIAL_ADDER_OVF_EN
    logic             w_ovf;
`endif

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (r_clk),
        .rst   (r_rst),
        .start (r_start),
        .a     (r_a),
        .b     (r_b),
        .busy  (w_busy),
        .done  (w_done),
        .S     (w_s),
        .C     (w_c)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .OVF   (w_ovf)
`endif
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] last_s = '0;
    logic       last_c = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Scoreboard: every done pulse consumes one queued expectation.
    always @(negedge r_clk) begin
        if (r_rst === 1'b0 && w_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: actual 1 required 0 (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("sum_S", 32'(w_s), 32'(mon_e.s));
                chk("carry_C", 32'(w_c), 32'(mon_e.c));
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf_OVF", 32'(w_ovf), 32'(mon_e.o));
`endif
            end
        end
    end

    // Drive one request at the current negedge and follow it to done.
    // inj:   pulse start with FF/FF during the 3rd busy cycle (must be ignored)
    // chain: return at the done negedge so the caller can start back-to-back
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb2, input logic [7:0] es,
                         input logic ec, input logic eo, input bit inj, input bit chain);
        int   busy_cnt;
        bit   got;
        bit   hold_ok;
        exp_t e;
        busy_cnt = 0;
        got      = 1'b0;
        hold_ok  = 1'b1;
        e.s = es;
        e.c = ec;
        e.o = eo;
        r_start = 1'b1;
        r_a     = ta;
        r_b     = tb2;
        sb.push_back(e);
        @(negedge r_clk);
        r_start = 1'b0;
        r_a     = 8'($urandom);
        r_b     = 8'($urandom);
        chk("busy_rise", 32'(w_busy), 32'd1);
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (w_done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (w_busy === 1'b1) busy_cnt++;
            if (w_s !== last_s || w_c !== last_c) hold_ok = 1'b0;
            if (inj && busy_cnt == 3) begin
                r_start = 1'b1;
                r_a     = 8'hFF;
                r_b     = 8'hFF;
            end else begin
                r_start = 1'b0;
            end
            @(negedge r_clk);
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
        chk("hold_during_add", 32'(hold_ok), 32'd1);
        last_s = es;
        last_c = ec;
        if (!chain) begin
            @(negedge r_clk);
            chk("done_one_cycle", 32'(w_done), 32'd0);
            chk("idle_after_done", 32'(w_busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vt[10];
        int         dn;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [8:0] sum9;

        vt[0] = '{8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vt[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vt[3] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vt[4] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
        vt[5] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vt[6] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
        vt[7] = '{8'h64, 8'h64, 8'hC8, 1'b0, 1'b1};
        vt[8] = '{8'hC8, 8'hC8, 8'h90, 1'b1, 1'b0};
        vt[9] = '{8'h7F, 8'h7F, 8'hFE, 1'b0, 1'b1};

        // Asynchronous reset, checked between clock edges.
        #2 r_rst = 1'b1;
        #1;
        chk("rst_busy", 32'(w_busy), 32'd0);
        chk("rst_done", 32'(w_done), 32'd0);
        chk("rst_S", 32'(w_s), 32'd0);
        chk("rst_C", 32'(w_c), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_OVF", 32'(w_ovf), 32'd0);
`endif
        repeat (2) @(negedge r_clk);
        r_rst = 1'b0;
        @(negedge r_clk);

        for (int i = 0; i < 10; i++)
            do_op(vt[i].a, vt[i].b, vt[i].s, vt[i].c, vt[i].o, 1'b0, 1'b0);

        // Start re-asserted during ADD must be ignored.
        do_op(8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0);
        dn = 0;
        repeat (WIDTH + 3) begin
            @(negedge r_clk);
            if (w_done === 1'b1) dn++;
        end
        chk("ignored_start_no_done", 32'(dn), 32'd0);

        // Back-to-back: start held through the done cycle.
        do_op(8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op(8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset during the 4th ADD cycle; start held high during reset.
        r_start = 1'b1;
        r_a     = 8'hAA;
        r_b     = 8'h55;
        @(negedge r_clk);
        r_start = 1'b0;
        repeat (3) @(negedge r_clk);
        r_rst   = 1'b1;
        r_start = 1'b1;
        #1;
        chk("midrst_busy", 32'(w_busy), 32'd0);
        chk("midrst_done", 32'(w_done), 32'd0);
        chk("midrst_S", 32'(w_s), 32'd0);
        chk("midrst_C", 32'(w_c), 32'd0);
        repeat (2) @(negedge r_clk);
        chk("start_in_rst_busy", 32'(w_busy), 32'd0);
        r_rst   = 1'b0;
        r_start = 1'b0;
        last_s  = '0;
        last_c  = 1'b0;
        dn = 0;
        repeat (WIDTH + 3) begin
            @(negedge r_clk);
            if (w_done === 1'b1) dn++;
        end
        chk("aborted_no_done", 32'(dn), 32'd0);
        do_op(8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random operands against an arithmetic model.
        for (int i = 0; i < 6; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            sum9 = {1'b0, ra} + {1'b0, rb};
            do_op(ra, rb, sum9[7:0], sum9[8],
                  (ra[7] == rb[7]) && (sum9[7] != ra[7]), 1'b0, (i % 2) == 1);
        end
        repeat (2) @(negedge r_clk);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 Port: a  input  WIDTH  augend, unsigned (two's complement when overflow detection is compiled in).
REQ-006 Port: b  input  WIDTH  addend, same encoding as a.
REQ-007 Port: busy  output  1  high while bit-serial addition is in progress.
REQ-008 Port: done  output  1  single-cycle pulse marking S and C valid.
REQ-009 Port: S  output  WIDTH  registered sum.
REQ-010 Port: C  output  1  registered carry-out of the MSB.

Function
REQ-011 FSM states: IDLE, ADD, DONE. busy = (state==ADD); done = (state==DONE).
REQ-012 Accepting state: start is accepted only when busy=0, i.e. in IDLE or DONE.
REQ-013 Accepting an operation: a and b are latched into internal shift registers, the internal carry is cleared, the bit counter is cleared, and the FSM enters ADD.
REQ-014 ADD, each cycle: one bit is processed LSB-first.
  - sum bit = a0 ^ b0 ^ cin
  - cout = majority(a0, b0, cin)
  - the sum bit is shifted in at the MSB end of the internal sum register
  - the operand registers shift right by one
  - the counter increments
REQ-015 ADD exit: after exactly WIDTH ADD cycles, the FSM enters DONE, copies the internal sum into S and the final carry into C.
REQ-016 Latency: start accepted at edge k results in done=1 during the cycle following edge k+WIDTH; done stays high for exactly one cycle.
REQ-017 Output hold: S and C hold their values from DONE until the next completion; they never show partial results.
REQ-018 Return to IDLE: from DONE with start=0, the FSM returns to IDLE.
REQ-019 Back-to-back: from DONE with start=1, the new operands are accepted and the FSM enters ADD directly, giving zero idle cycles.
REQ-020 start while busy: asserting start while busy=1 is ignored; the operands and in-flight operation are unaffected.
REQ-021 Wrap-around: the result is modulo 2^WIDTH in S, with the 2^WIDTH term reported in C (e.g. all-ones + 1 gives S=0, C=1).
REQ-022 Internal counter: it is clog2(WIDTH)+1 bits wide and never wraps within an operation.

Reset
REQ-023 rst=1 forces, immediately and independent of clk:
  - state=IDLE
  - busy=0, done=0
  - S=0, C=0
  - internal shift registers, carry and counter = 0
REQ-024 Reset mid-operation: assertion during ADD or DONE aborts the operation with no done pulse; after deassertion the next accepted start behaves as from power-up.
REQ-025 Start during reset: start is ignored while rst=1.

Configuration
REQ-026 Macro SERIAL_ADDER_OVF_EN, when defined, adds port: OVF  output  1  signed two's-complement overflow.
REQ-027 With the macro defined:
  - OVF = carry into the MSB XOR carry out of the MSB
  - OVF is registered alongside S and C in DONE
  - OVF is held with S and C, and reset to 0
REQ-028 Without the macro: the OVF port and its logic are absent; all other behaviour is identical.

Verification
REQ-029 WIDTH=8, a=8'h05, b=8'h03, start for one cycle -> busy high 8 cycles, then done pulse with S=8'h08, C=0.
REQ-030 WIDTH=8, a=8'hFF, b=8'h01 -> S=8'h00, C=1 at done; a=8'h00, b=8'h00 -> S=8'h00, C=0.
REQ-031 Start a=8'h10, b=8'h20; re-assert start with a=8'hFF, b=8'hFF during ADD -> result S=8'h30, C=0; second request ignored.
REQ-032 Assert rst at 4th ADD cycle of a=8'hAA, b=8'h55 -> busy=0, done=0, S=0, C=0 immediately; no done pulse; next op a=8'h01, b=8'h01 gives S=8'h02.
REQ-033 Start held high through DONE with new operands a=8'h80, b=8'h80 -> second busy period begins the cycle after done; result S=8'h00, C=1.
REQ-034 With SERIAL_ADDER_OVF_EN: a=8'h7F, b=8'h01 -> S=8'h80, C=0, OVF=1; a=8'hFF, b=8'h01 -> OVF=0.
